// File: rtl/display_bcd_n.sv
// Sequential binary-to-BCD (double-dabble) converter driving DIGITS active-low 7-segment digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module display_bcd_n #(
  parameter int DIGITS = 2,
  parameter int WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [WIDTH-1:0]      in_value_i,
  output logic                  in_ready_o,
  output logic [7*DIGITS-1:0]   seg_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic [BW-1:0]        bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [7*DIGITS-1:0]  seg_q, seg_d, disp;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic                 nz;
`endif

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b0000001;
      4'd1:    dec7 = 7'b1001111;
      4'd2:    dec7 = 7'b0010010;
      4'd3:    dec7 = 7'b0000110;
      4'd4:    dec7 = 7'b1001100;
      4'd5:    dec7 = 7'b0100100;
      4'd6:    dec7 = 7'b0100000;
      4'd7:    dec7 = 7'b0001111;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0000100;
      default: dec7 = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction applied to every digit before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Display image of the finished conversion, scanned from the top digit down.
  always_comb begin
    disp = '1;
`ifdef LEADING_ZERO_BLANK_EN
    nz = 1'b0;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_q[4*i +: 4] != 4'd0) nz = 1'b1;
`endif
      if (ovf_acc_q)
        disp[7*i +: 7] = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
      else if (!nz && i != 0)
        disp[7*i +: 7] = SEG_BLANK;
`endif
      else
        disp[7*i +: 7] = dec7(bcd_q[4*i +: 4]);
    end
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    seg_d     = seg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          value_d   = in_value_i;
          bcd_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d     = {bcd_adj[BW-2:0], value_q[WIDTH-1]};
        ovf_acc_d = ovf_acc_q | bcd_adj[BW-1];
        value_d   = value_q << 1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = UPDATE;
      end
      UPDATE: begin
        seg_d   = disp;
        ovf_d   = ovf_acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      value_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      seg_q     <= '1;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      seg_q     <= seg_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign in_ready_o = (state_q == IDLE);
  assign seg_o      = seg_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/display_bcd_n.md
DISPLAY_BCD_N -- requirements
Module: display_bcd_n

Interface
REQ-001 Parameter DIGITS, default 2, number of 7-segment digits driven (legal range 1..8).
REQ-002 Parameter WIDTH, default 8, width of the unsigned binary input (legal range 1..27).
REQ-003 clock  input  1  single clock for all state, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_value is presented for conversion.
REQ-006 in_value  input  WIDTH  unsigned binary value to display.
REQ-007 in_ready  output  1  block can accept a value this cycle.
REQ-008 seg  output  7*DIGITS  registered active-low segments; digit i occupies seg[7i+6:7i] with bit order a..g (MSB = a); digit 0 is the units digit.
REQ-009 done  output  1  one-cycle pulse when seg has been updated.
REQ-010 overflow  output  1  registered; last accepted value is >= 10^DIGITS.

Function
REQ-011 A value SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_value is captured then, and later changes are ignored.
REQ-012 The FSM SHALL have states IDLE, SHIFT and UPDATE: IDLE->SHIFT on accept; SHIFT->UPDATE after exactly WIDTH shift edges; UPDATE->IDLE on the next edge.
REQ-013 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored, with no queuing.
REQ-014 Conversion SHALL be sequential shift-add-3 (double-dabble) into DIGITS BCD digits, one input bit per SHIFT cycle.
REQ-015 Overflow SHALL be set when any 1 bit is shifted out of the top BCD digit during conversion.
REQ-016 On the UPDATE edge the block SHALL register seg, overflow and done=1; done returns to 0 on the following edge.
REQ-017 Latency: accept at edge E, seg/overflow/done valid after edge E+WIDTH+1; in_ready is low for WIDTH+1 cycles.
REQ-018 Digit encoding (a..g, 0 = lit): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111, dash=1111110.
REQ-019 With overflow, every digit SHALL show dash, regardless of configuration.
REQ-020 Any digit code above 9 SHALL decode to blank (defensive default).
REQ-021 seg SHALL hold its last value between updates.

Reset
REQ-022 While reset=0: state=IDLE, in_ready=1, seg = all digits blank (1111111), done=0, overflow=0, BCD/shift registers and counter cleared.
REQ-023 Reset mid-conversion SHALL abort it immediately (asynchronously); the aborted value is never displayed.
REQ-024 After reset release, the first rising edge SHALL be able to accept a value.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit show blank; digit 0 always shows its value (value 0 shows "0").
REQ-026 Macro LEADING_ZERO_BLANK_EN undefined: all DIGITS digits show their decimal value, including leading zeros.
REQ-027 The macro SHALL NOT affect latency, handshake or overflow behaviour.

Verification (DIGITS=2, WIDTH=8)
REQ-028 Assert reset=0, then release -> seg=14'b11111111111111, in_ready=1, done=0, overflow=0.
REQ-029 Accept 42 at edge E -> after E+9: digit1=1001100, digit0=0010010, overflow=0, done high exactly one cycle.
REQ-030 Accept 7 -> digit0=0001111; digit1=1111111 with LEADING_ZERO_BLANK_EN, 0000001 without.
REQ-031 Accept 150 -> overflow=1, both digits 1111110; then accept 99 -> overflow=0, both digits 0000100.
REQ-032 Accept 42, then hold in_valid=1 with in_value=13 during conversion -> 13 not accepted, display shows 42, in_ready low for 9 cycles, then 13 accepted on the first IDLE edge.
REQ-033 Accept 42, then assert reset=0 at E+4 -> seg blank and in_ready=1 immediately, no done pulse; after release, accept 5 -> correct display 9 edges later.
